// File: rtl/led_count_sequencer.sv
// LED-counter sequencer: waits for PLL lock, settles, then steps a WIDTH-bit
// up/down count on a prescaled single-cycle tick and drives a one-hot LED vector.
module led_count_sequencer #(
    parameter int DIV_MAX    = 12000000,
    parameter int SETTLE_CYC = 1024,
    parameter int WIDTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lock,
    input  logic                    direction,
    input  logic                    hold,
    output logic [WIDTH-1:0]        count,
    output logic [(2**WIDTH)-1:0]   led,
    output logic                    tick,
    output logic                    dir_q,
    output logic [1:0]              state
);

    localparam int LED_W = 2**WIDTH;
    localparam int PW    = $clog2(DIV_MAX);
    localparam int SW    = $clog2(SETTLE_CYC + 1);

    localparam logic [PW-1:0]    PRESC_LAST  = PW'(DIV_MAX - 1);
    localparam logic [PW-1:0]    PRESC_ONE   = PW'(1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
    localparam logic [WIDTH-1:0] COUNT_ONE   = WIDTH'(1);
    localparam logic [LED_W-1:0] LED_ONE     = LED_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic lock_meta, lock_s;
    logic dir_meta, dir_s;
    logic hold_meta, hold_s;

    logic [PW-1:0]    presc_q, presc_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [WIDTH-1:0] count_d;
    logic             dir_d;
    logic             tick_d;
    logic [LED_W-1:0] led_d;

    // Two-flop synchronizers for the asynchronous board inputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            dir_meta  <= 1'b0;
            dir_s     <= 1'b0;
            hold_meta <= 1'b0;
            hold_s    <= 1'b0;
        end else begin
            lock_meta <= lock;
            lock_s    <= lock_meta;
            dir_meta  <= direction;
            dir_s     <= dir_meta;
            hold_meta <= hold;
            hold_s    <= hold_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= WAIT_LOCK;
        else        state_q <= state_d;
    end

    // Lock loss dominates hold, which dominates the tick.
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_LOCK: if (lock_s) state_d = SETTLE;
            SETTLE: begin
                if (!lock_s)                    state_d = WAIT_LOCK;
                else if (settle_q == SETTLE_LAST) state_d = RUN;
            end
            RUN: begin
                if (!lock_s)     state_d = WAIT_LOCK;
                else if (hold_s) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s)      state_d = WAIT_LOCK;
                else if (!hold_s) state_d = RUN;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_comb begin
        presc_d  = presc_q;
        settle_d = '0;
        count_d  = count;
        dir_d    = dir_q;
        tick_d   = 1'b0;
        unique case (state_q)
            WAIT_LOCK: presc_d = '0;
            SETTLE: begin
                presc_d = '0;
                if (state_d == SETTLE) settle_d = settle_q + SETTLE_ONE;
            end
            RUN: begin
                if (state_d == RUN) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        dir_d   = dir_s;
                        count_d = dir_q ? count + COUNT_ONE : count - COUNT_ONE;
                    end else begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                end else if (state_d == WAIT_LOCK) begin
                    presc_d = '0;
                end
            end
            HOLD: if (state_d == WAIT_LOCK) presc_d = '0;
            default: presc_d = '0;
        endcase
        // Decoding the next count keeps led and count changing on the same edge.
        led_d = (state_d == RUN || state_d == HOLD) ? (LED_ONE << count_d) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q  <= '0;
            settle_q <= '0;
            count    <= '0;
            dir_q    <= 1'b1;
            tick     <= 1'b0;
            led      <= '0;
        end else begin
            presc_q  <= presc_d;
            settle_q <= settle_d;
            count    <= count_d;
            dir_q    <= dir_d;
            tick     <= tick_d;
            led      <= led_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_led_count_sequencer.sv
// Bench for led_count_sequencer: hand-derived vector table for the documented scenarios,
// async-reset check, then random switch/lock activity against a behavioural model.
module tb_led_count_sequencer;

    localparam int DIV_MAX    = 4;
    localparam int SETTLE_CYC = 8;
    localparam int WIDTH      = 4;
    localparam int NVAL       = 2**WIDTH;

    localparam int M_WAIT   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_RUN    = 2;
    localparam int M_HOLD   = 3;

    logic              clk;
    logic              rst_n;
    logic              lock;
    logic              direction;
    logic              hold;
    logic [WIDTH-1:0]  count;
    logic [NVAL-1:0]   led;
    logic              tick;
    logic              dir_q;
    logic [1:0]        state;

    int n_checks = 0;
    int n_errors = 0;

    led_count_sequencer #(
        .DIV_MAX    (DIV_MAX),
        .SETTLE_CYC (SETTLE_CYC),
        .WIDTH      (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .lock      (lock),
        .direction (direction),
        .hold      (hold),
        .count     (count),
        .led       (led),
        .tick      (tick),
        .dir_q     (dir_q),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pins become visible to the controller two edges later.
    bit lk_h[2], dr_h[2], hd_h[2];
    int m_mode, m_phase, m_settled, m_cnt;
    bit m_dq, m_tk;

    task automatic model_reset();
        lk_h = '{1'b0, 1'b0};
        dr_h = '{1'b0, 1'b0};
        hd_h = '{1'b0, 1'b0};
        m_mode = M_WAIT; m_phase = 0; m_settled = 0; m_cnt = 0;
        m_dq = 1'b1; m_tk = 1'b0;
    endtask

    task automatic model_edge();
        bit l, d, h;
        if (!rst_n) begin
            model_reset();
            return;
        end
        l = lk_h[1]; d = dr_h[1]; h = hd_h[1];
        lk_h[1] = lk_h[0]; lk_h[0] = lock;
        dr_h[1] = dr_h[0]; dr_h[0] = direction;
        hd_h[1] = hd_h[0]; hd_h[0] = hold;
        m_tk = 1'b0;
        case (m_mode)
            M_WAIT: begin
                m_phase = 0; m_settled = 0;
                if (l) m_mode = M_SETTLE;
            end
            M_SETTLE: begin
                if (!l) begin
                    m_mode = M_WAIT; m_settled = 0;
                end else if (m_settled + 1 == SETTLE_CYC) begin
                    m_mode = M_RUN; m_settled = 0; m_phase = 0;
                end else begin
                    m_settled++;
                end
            end
            M_RUN: begin
                if (!l) begin
                    m_mode = M_WAIT; m_phase = 0;
                end else if (h) begin
                    m_mode = M_HOLD;
                end else if (m_phase + 1 == DIV_MAX) begin
                    m_tk = 1'b1;
                    m_cnt = (m_cnt + (m_dq ? 1 : NVAL - 1)) % NVAL;
                    m_dq = d;
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
            end
            default: begin
                if (!l) begin
                    m_mode = M_WAIT; m_phase = 0;
                end else if (!h) begin
                    m_mode = M_RUN;
                end
            end
        endcase
    endtask

    task automatic compare_model();
        int exp_led;
        exp_led = (m_mode >= M_RUN) ? (1 << m_cnt) : 0;
        check("model_state", 32'(state), m_mode);
        check("model_count", 32'(count), m_cnt);
        check("model_tick",  32'(tick),  32'(m_tk));
        check("model_dir_q", 32'(dir_q), 32'(m_dq));
        check("model_led",   32'(led),   exp_led);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        compare_model();
    endtask

    typedef struct {
        bit         lock;
        bit         dir;
        bit         hold;
        int         ncyc;
        logic [1:0] st;
        logic [3:0] cnt;
        bit         dq;
        bit         tk;
        logic [15:0] led;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int l, input int d, input int h, input int n,
                       input int st, input int cnt, input int dq, input int tk, input int ld);
        vec_t v;
        v.lock = (l != 0); v.dir = (d != 0); v.hold = (h != 0); v.ncyc = n;
        v.st = 2'(st); v.cnt = 4'(cnt); v.dq = (dq != 0); v.tk = (tk != 0); v.led = 16'(ld);
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; lock = 1'b0; direction = 1'b1; hold = 1'b0;
        model_reset();

        //   lock dir hold ncyc | state cnt dq tick led
        add(0, 1, 0, 50,   0,  0, 1, 0, 'h0000);  // idle without lock
        add(1, 1, 0,  2,   0,  0, 1, 0, 'h0000);  // lock still in synchronizer
        add(1, 1, 0,  1,   1,  0, 1, 0, 'h0000);  // SETTLE 3 cycles after lock
        add(1, 1, 0,  7,   1,  0, 1, 0, 'h0000);
        add(1, 1, 0,  1,   2,  0, 1, 0, 'h0001);  // RUN after 8 settle cycles
        add(1, 1, 0,  3,   2,  0, 1, 0, 'h0001);
        add(1, 1, 0,  1,   2,  1, 1, 1, 'h0002);  // first tick
        add(1, 1, 0, 60,   2,  0, 1, 1, 'h0001);  // 16 ticks wrap up
        add(1, 0, 0,  4,   2,  1, 0, 1, 'h0002);  // still up, direction latched
        add(1, 0, 0,  4,   2,  0, 0, 1, 'h0001);  // now down
        add(1, 0, 0,  4,   2, 15, 0, 1, 'h8000);  // wrap down 0->15
        add(1, 0, 0,  1,   2, 15, 0, 0, 'h8000);
        add(1, 0, 1,  3,   3, 15, 0, 0, 'h8000);  // hold lands on last prescaler cycle
        add(1, 0, 1, 20,   3, 15, 0, 0, 'h8000);
        add(1, 0, 0,  2,   3, 15, 0, 0, 'h8000);
        add(1, 0, 0,  1,   2, 15, 0, 0, 'h8000);  // back to RUN
        add(1, 0, 0,  1,   2, 14, 0, 1, 'h4000);  // tick one cycle later
        add(1, 1, 0,  4,   2, 13, 1, 1, 'h2000);
        add(1, 1, 0, 48,   2,  9, 1, 1, 'h0200);  // up to 9
        add(0, 1, 0,  2,   2,  9, 1, 0, 'h0200);
        add(0, 1, 0,  1,   0,  9, 1, 0, 'h0000);  // lock lost, count retained
        add(0, 1, 0, 10,   0,  9, 1, 0, 'h0000);
        add(1, 1, 0,  3,   1,  9, 1, 0, 'h0000);
        add(1, 1, 0,  7,   1,  9, 1, 0, 'h0000);
        add(1, 1, 0,  1,   2,  9, 1, 0, 'h0200);  // full settle again
        add(1, 1, 0,  4,   2, 10, 1, 1, 'h0400);  // resume 9->10

        repeat (3) cycle();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            lock = vecs[i].lock; direction = vecs[i].dir; hold = vecs[i].hold;
            repeat (vecs[i].ncyc) cycle();
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_dir_q", i), 32'(dir_q), 32'(vecs[i].dq));
            check($sformatf("vec%0d_tick",  i), 32'(tick),  32'(vecs[i].tk));
            check($sformatf("vec%0d_led",   i), 32'(led),   32'(vecs[i].led));
        end

        // Asynchronous reset in the middle of a tick cycle.
        check("pre_reset_tick", 32'(tick), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_tick",  32'(tick),  32'd0);
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_led",   32'(led),   32'd0);
        check("async_rst_dir_q", 32'(dir_q), 32'd1);
        model_reset();
        repeat (3) cycle();
        lock = 1'b1; direction = 1'b1; hold = 1'b0;
        rst_n = 1'b1;

        for (int n = 0; n < 4000; n++) begin
            cycle();
            if (lock ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0)) lock = ~lock;
            if ($urandom_range(0, 39) == 0) direction = ~direction;
            if (hold ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 29) == 0)) hold = ~hold;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
